// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- fetch-stage program counter and next-PC selection (MIPS datapath)
//
// Holds the PC register and picks the next PC from sequential, beq/bne branch,
// j/jal jump and jr register-target sources. Exceptions redirect to EXC_PC and
// stalls hold the PC. Reset is synchronous and active-high.
//
// Optional feature (macro NPC_RAS_EN): return-address stack. Each jal pushes its
// link address. Each jr pops the stack and is checked against the top entry.
// If NPC_RAS_EN is not defined, the RAS outputs are tied to zero. PC behaviour is
// the same in both builds.
//
// Ports:
//   clk, rst        clock (rising edge); synchronous active-high reset
//   stall, exc      hold PC; redirect to EXC_PC (exc beats stall)
//   npc_sel[2:0]    000 seq, 001 beq, 010 jal, 011 j, 100 jr, 101 bne, 11x seq
//   zero            ALU equality result for beq/bne
//   imm[25:0]       instr[25:0]; branches use imm[15:0]
//   target[31:0]    GPR[rs] for jr
//   pc              current PC (registered)
//   pcp4            pc + 4 (combinational, jal link value)
//   npc             selected next PC before stall/exc override
//   misalign        jr selected with target[1:0] != 0
//   ras_top         RAS top entry, 0 when empty
//   ras_valid       RAS non-empty
//   ras_mispredict  jr taken with empty RAS or ras_top != target
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000),
  parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(32'h0000_4180),
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              exc,
  input  logic [2:0]        npc_sel,
  input  logic              zero,
  input  logic [25:0]       imm,
  input  logic [31:0]       target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcp4,
  output logic [ADDR_W-1:0] npc,
  output logic              misalign,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_valid,
  output logic              ras_mispredict
);

  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BEQ = 3'b001;
  localparam logic [2:0] SEL_JAL = 3'b010;
  localparam logic [2:0] SEL_J   = 3'b011;
  localparam logic [2:0] SEL_JR  = 3'b100;
  localparam logic [2:0] SEL_BNE = 3'b101;

  // Jumps keep the pcp4 bits above bit 27. Those bits do not exist when ADDR_W is 28.
  localparam logic [ADDR_W-1:0] HI_MASK = {ADDR_W{1'b1}} << 5'd28;

  // The low two bits of the PC are always zero, so they are not stored.
  logic [ADDR_W-1:2] pc_r;
  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] br_tgt_s;
  logic [ADDR_W-1:0] jump_s;
  logic [ADDR_W-1:0] jr_s;

  assign pc       = {pc_r, 2'b00};
  assign pcp4     = pc + ADDR_W'(32'd4);
  assign br_off_s = {{(ADDR_W-18){imm[15]}}, imm[15:0], 2'b00};
  assign br_tgt_s = pcp4 + br_off_s;
  assign jump_s   = (pcp4 & HI_MASK) | ADDR_W'({imm, 2'b00});
  assign jr_s     = {target[ADDR_W-1:2], 2'b00};
  assign misalign = (npc_sel == SEL_JR) && (target[1:0] != 2'b00);

  // Next-PC source selection; reserved encodings fall back to sequential.
  always_comb begin
    npc = pcp4;
    case (npc_sel)
      SEL_SEQ: npc = pcp4;
      SEL_BEQ: npc = zero ? br_tgt_s : pcp4;
      SEL_BNE: npc = zero ? pcp4 : br_tgt_s;
      SEL_JAL: npc = jump_s;
      SEL_J:   npc = jump_s;
      SEL_JR:  npc = jr_s;
      default: npc = pcp4;
    endcase
  end

  // PC register: reset beats exception, exception beats stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC[ADDR_W-1:2];
    end else if (exc) begin
      pc_r <= EXC_PC[ADDR_W-1:2];
    end else if (stall) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= npc[ADDR_W-1:2];
    end
  end

`ifdef NPC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // sp_r points at the next free slot. When the stack is full, that slot is the
  // oldest entry, so a push there overwrites it.
  logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [PTR_W-1:0]  top_idx_s;
  logic              update_s;
  logic              push_s;
  logic              pop_s;

  assign update_s  = !rst && !exc && !stall;
  assign push_s    = update_s && (npc_sel == SEL_JAL);
  assign pop_s     = update_s && (npc_sel == SEL_JR) && ras_valid;
  assign top_idx_s = sp_r - PTR_W'(1);

  assign ras_valid      = (cnt_r != CNT_W'(0));
  assign ras_top        = ras_valid ? ras_mem_r[top_idx_s] : {ADDR_W{1'b0}};
  assign ras_mispredict = update_s && (npc_sel == SEL_JR) &&
                          (!ras_valid || (ras_top != target[ADDR_W-1:0]));

  // Circular return-address stack. The count saturates at RAS_DEPTH on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_r  <= PTR_W'(0);
      cnt_r <= CNT_W'(0);
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_r[i] <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      ras_mem_r[sp_r] <= pcp4;
      sp_r            <= sp_r + PTR_W'(1);
      cnt_r           <= (cnt_r == CNT_W'(RAS_DEPTH)) ? cnt_r : cnt_r + CNT_W'(1);
    end else if (pop_s) begin
      sp_r  <= top_idx_s;
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      sp_r  <= sp_r;
      cnt_r <= cnt_r;
    end
  end
`else
  assign ras_top        = {ADDR_W{1'b0}};
  assign ras_valid      = 1'b0;
  assign ras_mispredict = 1'b0;
`endif

endmodule
